// File: rtl/hazard_sequencer_if.sv
// Hazard-controller bus: decode-stage fields and events in, forwarding and
// pipeline stall/flush/freeze controls out. Counter signals exist only when
// HAZARD_PERF_EN is defined.
interface hazard_sequencer_if #(
    parameter int unsigned A_WIDTH = 5
`ifdef HAZARD_PERF_EN
    ,
    parameter int unsigned CNT_WIDTH = 32
`endif
);

    // Decode-stage fields of the instruction about to enter Execute
    logic [A_WIDTH-1:0] Rs1D;
    logic [A_WIDTH-1:0] Rs2D;
    logic [A_WIDTH-1:0] RdD;
    logic               RegWriteD;
    logic [1:0]         ResultSrcD;

    // Pipeline events
    logic               PCSrcE;
    logic               MemBusyM;

    // Hazard controls
    logic [1:0]         ForwardAE;
    logic [1:0]         ForwardBE;
    logic               StallF;
    logic               StallD;
    logic               FlushD;
    logic               FlushE;
    logic               FreezeEMW;

`ifdef HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] LoadStallCnt;
    logic [CNT_WIDTH-1:0] FlushCnt;
    logic [CNT_WIDTH-1:0] MemWaitCnt;

    // Pipeline side: supplies decode fields and events, consumes controls
    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE, MemBusyM,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FreezeEMW,
        input  LoadStallCnt, FlushCnt, MemWaitCnt
    );

    // Hazard unit side
    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE, MemBusyM,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FreezeEMW,
        output LoadStallCnt, FlushCnt, MemWaitCnt
    );
`else
    // Pipeline side: supplies decode fields and events, consumes controls
    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE, MemBusyM,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FreezeEMW
    );

    // Hazard unit side
    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE, MemBusyM,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FreezeEMW
    );
`endif

endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller for the five-stage RV32I core.
// Shadows the register-address/write-control fields of the E, M and W stages
// and derives forwarding selects, load-use interlocks, branch flushes and
// data-memory freezes from them. Define HAZARD_PERF_EN to add saturating
// performance counters (load stalls, branch flushes, memory-wait cycles).
module hazard_sequencer #(
    parameter int unsigned A_WIDTH = 5
`ifdef HAZARD_PERF_EN
    ,
    parameter int unsigned CNT_WIDTH = 32
`endif
) (
    input logic             clk,
    input logic             rst,
    hazard_sequencer_if.slave bus
);

    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [1:0] FWD_NONE    = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;

    // Execute-stage shadow
    logic [A_WIDTH-1:0] rs1_e;
    logic [A_WIDTH-1:0] rs2_e;
    logic [A_WIDTH-1:0] rd_e;
    logic               reg_write_e;
    logic [1:0]         result_src_e;

    // Memory- and Writeback-stage shadows
    logic [A_WIDTH-1:0] rd_m;
    logic               reg_write_m;
    logic [A_WIDTH-1:0] rd_w;
    logic               reg_write_w;

    logic               lw_stall;
    logic               flush_e;

    // Nearest producer wins: Memory stage over Writeback; x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [A_WIDTH-1:0] rs,
                                           input logic [A_WIDTH-1:0] rdm,
                                           input logic               rwm,
                                           input logic [A_WIDTH-1:0] rdw,
                                           input logic               rww);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (rwm && (rdm != '0) && (rdm == rs)) begin
            sel = FWD_M;
        end else if (rww && (rdw != '0) && (rdw == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    // Load-use detection; a taken branch squashes the consumer, so no stall.
    always_comb begin
        lw_stall = reg_write_e
                 & (result_src_e == RESULT_LOAD)
                 & (rd_e != '0)
                 & ((rd_e == bus.Rs1D) | (rd_e == bus.Rs2D))
                 & ~bus.PCSrcE;
        flush_e  = (lw_stall | bus.PCSrcE) & ~bus.MemBusyM;
    end

    // Forwarding selects and pipeline controls; MemBusyM suppresses flushes.
    always_comb begin
        bus.ForwardAE = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
        bus.ForwardBE = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
        bus.StallF    = lw_stall | bus.MemBusyM;
        bus.StallD    = lw_stall | bus.MemBusyM;
        bus.FlushD    = bus.PCSrcE & ~bus.MemBusyM;
        bus.FlushE    = flush_e;
        bus.FreezeEMW = bus.MemBusyM;
    end

    // Shadow pipeline: holds while frozen, else shifts with a bubble on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_e        <= '0;
            rs2_e        <= '0;
            rd_e         <= '0;
            reg_write_e  <= 1'b0;
            result_src_e <= 2'b00;
            rd_m         <= '0;
            reg_write_m  <= 1'b0;
            rd_w         <= '0;
            reg_write_w  <= 1'b0;
        end else if (!bus.MemBusyM) begin
            rd_w        <= rd_m;
            reg_write_w <= reg_write_m;
            rd_m        <= rd_e;
            reg_write_m <= reg_write_e;
            if (flush_e) begin
                rs1_e        <= '0;
                rs2_e        <= '0;
                rd_e         <= '0;
                reg_write_e  <= 1'b0;
                result_src_e <= 2'b00;
            end else begin
                rs1_e        <= bus.Rs1D;
                rs2_e        <= bus.Rs2D;
                rd_e         <= bus.RdD;
                reg_write_e  <= bus.RegWriteD;
                result_src_e <= bus.ResultSrcD;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] load_stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;
    logic [CNT_WIDTH-1:0] mem_wait_cnt;

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_stall_cnt <= '0;
            flush_cnt      <= '0;
            mem_wait_cnt   <= '0;
        end else begin
            if (lw_stall && !bus.MemBusyM && (load_stall_cnt != '1)) begin
                load_stall_cnt <= load_stall_cnt + CNT_ONE;
            end
            if (bus.PCSrcE && !bus.MemBusyM && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
            if (bus.MemBusyM && (mem_wait_cnt != '1)) begin
                mem_wait_cnt <= mem_wait_cnt + CNT_ONE;
            end
        end
    end

    // Counter outputs
    always_comb begin
        bus.LoadStallCnt = load_stall_cnt;
        bus.FlushCnt     = flush_cnt;
        bus.MemWaitCnt   = mem_wait_cnt;
    end
`endif

endmodule
